// File: rtl/cache_types.sv
// Shared types, geometry helpers and the PLRU victim walk for the
// parametrised LC-3b cache.
package cache_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam int MAX_WAYS = 8;

    function automatic int off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bits, input int sets);
        return addr_w - off_w(line_bits) - idx_w(sets);
    endfunction

    // Walk from the root; a 0 node sends the walk left (child 2n+1), a 1 right.
    function automatic logic [2:0] plru_victim(input logic [MAX_WAYS-2:0] tree,
                                               input int ways);
        int n;
        int lv;
        n  = 0;
        lv = $clog2(ways);
        for (int l = 0; l < 3; l++) begin
            if (l < lv) n = 2 * n + 1 + ((int'(tree) >> n) & 1);
        end
        return 3'(n - (ways - 1));
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: next tree bits after an access to `way`,
// and the way the current tree points at as victim.
module plru_tree
    import cache_types::*;
#(
    parameter int WAYS = 4,
    localparam int LV  = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] tree,
    input  logic [LV-1:0]   way,
    output logic [WAYS-2:0] next_tree,
    output logic [LV-1:0]   victim
);

    logic [MAX_WAYS-2:0] tree_ext;
    logic [2:0]          victim_full;

    assign tree_ext    = (MAX_WAYS-1)'(tree);
    assign victim_full = plru_victim(tree_ext, WAYS);
    assign victim      = victim_full[LV-1:0];

    // Every node on the access path is turned to point at the other subtree.
    always_comb begin
        int t;
        int n;
        int d;
        t = int'(tree);
        n = 0;
        d = 0;
        for (int l = 0; l < LV; l++) begin
            d = (int'(way) >> (LV - 1 - l)) & 1;
            if (d != 0) t = t & ~(1 << n);
            else        t = t | (1 << n);
            n = 2 * n + 1 + d;
        end
        next_tree = t[WAYS-2:0];
    end

endmodule

// File: rtl/param_cache.sv
// N-way set-associative write-back, write-allocate L1 cache between the
// LC-3b CPU port and line-wide physical memory, with tree PLRU replacement.
module param_cache
    import cache_types::*;
#(
    parameter int WAYS      = 4,
    parameter int SETS      = 8,
    parameter int LINE_BITS = 128,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic [ADDR_W-1:0]    mem_address,
    input  logic [15:0]          mem_wdata,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    input  logic                 pmem_resp,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    output logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_W-1:0]    pmem_address
);

    localparam int OFF_W  = off_w(LINE_BITS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BITS, SETS);
    localparam int WSEL_W = OFF_W - 1;
    localparam int LV     = $clog2(WAYS);
    localparam int LBIT_W = $clog2(LINE_BITS);

    logic [TAG_W-1:0]     tag_arr   [SETS][WAYS];
    logic [LINE_BITS-1:0] data_arr  [SETS][WAYS];
    logic [WAYS-1:0]      valid_arr [SETS];
    logic [WAYS-1:0]      dirty_arr [SETS];
    logic [WAYS-2:0]      plru_arr  [SETS];

    state_t          state, state_nx;
    logic [LV-1:0]   victim_q, victim_nx;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic [LBIT_W-1:0] wofs;

    assign req_tag = mem_address[ADDR_W-1 -: TAG_W];
    assign idx     = mem_address[OFF_W +: IDX_W];
    assign wsel    = mem_address[OFF_W-1:1];
    assign wofs    = {wsel, 4'b0000};

    logic          hit;
    logic [LV-1:0] hit_way;
    logic          has_free;
    logic [LV-1:0] free_way;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[idx][w] && tag_arr[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = LV'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[idx][w]) begin
                has_free = 1'b1;
                free_way = LV'(w);
            end
        end
    end

    logic [WAYS-2:0] plru_nx;
    logic [LV-1:0]   plru_vic;
    logic [LV-1:0]   miss_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree      (plru_arr[idx]),
        .way       (hit_way),
        .next_tree (plru_nx),
        .victim    (plru_vic)
    );

    assign miss_way = has_free ? free_way : plru_vic;

    logic [LINE_BITS-1:0] hit_line, merged_line, vic_line;
    logic [TAG_W-1:0]     vic_tag;
    logic [15:0]          cur_word;

    assign hit_line = data_arr[idx][hit_way];
    assign vic_line = data_arr[idx][victim_q];
    assign vic_tag  = tag_arr[idx][victim_q];
    assign cur_word = hit_line[wofs +: 16];

    always_comb begin
        merged_line = hit_line;
        merged_line[wofs +: 16] = {mem_byte_enable[1] ? mem_wdata[15:8] : cur_word[15:8],
                                   mem_byte_enable[0] ? mem_wdata[7:0]  : cur_word[7:0]};
    end

    logic hit_upd, wr_upd, wb_done, fill_done;

    always_comb begin
        state_nx     = state;
        victim_nx    = victim_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        hit_upd      = 1'b0;
        wr_upd       = 1'b0;
        wb_done      = 1'b0;
        fill_done    = 1'b0;
        if (!reset) begin
            case (state)
                CHECK: begin
                    if (mem_read || mem_write) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            hit_upd  = 1'b1;
                            wr_upd   = mem_write;
                            if (!mem_write) mem_rdata = cur_word;
                        end else begin
                            victim_nx = miss_way;
                            state_nx  = (valid_arr[idx][miss_way] && dirty_arr[idx][miss_way])
                                        ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {vic_tag, idx, {OFF_W{1'b0}}};
                    pmem_wdata   = vic_line;
                    if (pmem_resp) begin
                        wb_done  = 1'b1;
                        state_nx = FILL;
                    end
                end
                FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {req_tag, idx, {OFF_W{1'b0}}};
                    if (pmem_resp) begin
                        fill_done = 1'b1;
                        state_nx  = CHECK;
                    end
                end
                default: state_nx = CHECK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CHECK;
            victim_q <= '0;
        end else begin
            state    <= state_nx;
            victim_q <= victim_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (hit_upd) plru_arr[idx] <= plru_nx;
            if (wr_upd)  dirty_arr[idx][hit_way] <= 1'b1;
            if (wb_done) dirty_arr[idx][victim_q] <= 1'b0;
            if (fill_done) begin
                valid_arr[idx][victim_q] <= 1'b1;
                dirty_arr[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line storage is not reset; valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (wr_upd) data_arr[idx][hit_way] <= merged_line;
        if (fill_done) begin
            data_arr[idx][victim_q] <= pmem_rdata;
            tag_arr[idx][victim_q]  <= req_tag;
        end
    end

endmodule

// File: doc/param_cache.md
Name: param_cache

Overview:
- Parametrised successor of the fixed 2-way LC-3b L1 cache: N-way set-associative, write-back, write-allocate.
- Uses tree pseudo-LRU replacement, with configurable set count and line width.
- Sits between the CPU memory port (16-bit word, byte enables) and physical memory (one line per transfer).
- Adds a synchronous reset that invalidates the whole cache. The old block had no reset and a single LRU bit.

Parameters:
- WAYS, 4, associativity; power of 2, range 2..8.
- SETS, 8, number of sets; power of 2, at least 2.
- LINE_BITS, 128, line width; power of 2, at least 32.
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  byte mask for writes; bit1 = high byte.
- mem_address  in  ADDR_W  CPU byte address; bit0 ignored.
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  LINE_BITS  fill line.
- pmem_wdata  out  LINE_BITS  write-back line.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line write-back request.
- pmem_address  out  ADDR_W  line-aligned address; offset bits are 0.

Behaviour:
- Address split: OFF = log2(LINE_BITS/8) low bits; IDX = log2(SETS) next bits; remaining bits are the tag. Word select = address[OFF-1:1].
- Storage per set and way: valid, dirty, tag and data. Per set: PLRU tree of WAYS-1 bits.
- Reset: all valid, dirty and PLRU bits go to 0. State goes to CHECK. mem_resp, pmem_read and pmem_write go to 0; mem_rdata, pmem_address and pmem_wdata go to 0.
- Reset mid-transfer: the transfer is abandoned and dirty data is discarded. Memory must tolerate the dropped request.
- States: CHECK, WRITEBACK, FILL.
- CHECK:
  - A hit is a valid way whose tag equals the address tag (at most one).
  - On a hit, mem_resp=1 combinationally in the same cycle, giving 0 wait-state hits.
  - Read hit: mem_rdata = the selected word, combinational.
  - Write hit: at that clock edge, merge mem_wdata into the line under mem_byte_enable, set dirty, and update PLRU.
  - Read hit also updates PLRU.
  - mem_read and mem_write both high is treated as a write.
- Miss handling (in CHECK):
  - Victim = lowest-index invalid way. If all ways are valid, the victim is the PLRU way.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to FILL.
  - The victim index is registered on the transition and held until the fill completes.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp: clear the victim's dirty bit and go to FILL.
- FILL:
  - pmem_read=1, pmem_address = {request tag, index, 0}.
  - On pmem_resp: write the line, tag, valid=1 and dirty=0 into the victim way, then return to CHECK. The request then hits (the miss costs one extra CHECK cycle).
- pmem_read and pmem_write are never both high. Both hold steady until pmem_resp.
- No request in CHECK: no state change and no array writes.
- PLRU (tree, binary heap indexing):
  - Node bit 0 means the victim is in the left subtree.
  - On any access, each node on the path is set to point away from the accessed way.
  - The victim walk starts at the root.
- mem_resp is never asserted outside CHECK. mem_rdata is don't-care when mem_resp=0, but is driven 0 in WRITEBACK and FILL.

Decomposition:
- Package cache_types: lc3b_word, derived widths (OFF_W, IDX_W, TAG_W), state enum, and a function computing the PLRU victim.
- One sub-module, plru_tree (parameter WAYS):
  - Inputs: current tree bits, accessed way.
  - Outputs: next tree bits, victim way.
  - Purely combinational.
- Arrays and the FSM stay in param_cache.

Test Plan (WAYS=4, SETS=8, LINE_BITS=128; index = addr[6:4]):
- Reset, then read 0x0010 with pmem_rdata line word0 = 0xBEEF:
  - Required order: pmem_read with pmem_address=0x0010, then a hit.
  - mem_rdata=0xBEEF, mem_resp for 1 cycle.
  - pmem_write is never asserted.
- Write 0x0012 data 0x1234, mem_byte_enable=2'b01, line word1 previously 0xAAAA:
  - Hit with no pmem activity.
  - A read of 0x0012 then returns 0xAA34.
- Read 0x0010, 0x0090, 0x0110, 0x0190 (fills ways 0..3), then read 0x0210:
  - The victim is way0: pmem_read address 0x0210.
  - A later read of 0x0010 misses.
- Dirty eviction: write 0x0010 (tag A), fill the other 3 ways, then read 0x0210:
  - pmem_write at 0x0010 with the modified line comes first.
  - pmem_read at 0x0210 follows.
- Assert reset during a FILL (pmem_read=1):
  - pmem_read=0 in the next cycle.
  - A subsequent read of the same address misses.
- mem_read=mem_write=1 on a hit: the write is performed and mem_resp is asserted for exactly 1 cycle.
